product_accumulator: RTL and testbench

Sequential accumulate stage directly downstream of the 8×8 shift-and-add multiplier. It consumes a frame of unsigned 16-bit products over a valid/ready handshake and sums them into a wide accumulator, which gives a dot-product or MAC result. It presents the frame total, with a sticky overflow flag, on an output valid/ready handshake. Frame length is programmed per frame at `start`.

---
 rtl/product_accumulator.sv | 118 +++++++++++
 tb/tb_product_accumulator.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Frame accumulator placed after the 8x8 multiplier: sums LEN unsigned products
// into an ACC_W-bit total with a sticky carry-out flag, then holds the result.
module product_accumulator #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int LEN_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [PROD_W-1:0] i_in_prod,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [ACC_W-1:0]  o_out_sum,
  output logic              o_out_ovf,
  output logic              o_busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [LEN_W-1:0] r_cnt;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic             w_xfer;
  logic             w_last;
  logic [ACC_W:0]   w_sum;

  assign w_xfer = i_in_valid & r_in_ready;
  assign w_last = (r_cnt == {{(LEN_W-1){1'b0}}, 1'b1});
  // One extra bit so the carry out of the accumulator can feed the sticky flag.
  assign w_sum  = {1'b0, r_acc} + {{(ACC_W+1-PROD_W){1'b0}}, i_in_prod};

  // Next-state selection for the IDLE / ACCUM / HOLD sequence.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (i_len == {LEN_W{1'b0}}) begin
            w_state_nxt = S_HOLD;
          end else begin
            w_state_nxt = S_ACCUM;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACCUM: begin
        if (w_xfer && w_last) begin
          w_state_nxt = S_HOLD;
        end else begin
          w_state_nxt = S_ACCUM;
        end
      end
      S_HOLD: begin
        if (i_out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State plus handshake flags, registered off the next state so they carry no input path.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == S_ACCUM);
      r_out_valid <= (w_state_nxt == S_HOLD);
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  // Accumulator, sticky overflow and remaining-count datapath.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= {ACC_W{1'b0}};
      r_ovf <= 1'b0;
      r_cnt <= {LEN_W{1'b0}};
    end else if ((r_state == S_IDLE) && i_start) begin
      r_acc <= {ACC_W{1'b0}};
      r_ovf <= 1'b0;
      r_cnt <= i_len;
    end else if ((r_state == S_ACCUM) && w_xfer) begin
      r_acc <= w_sum[ACC_W-1:0];
      r_ovf <= r_ovf | w_sum[ACC_W];
      r_cnt <= r_cnt - {{(LEN_W-1){1'b0}}, 1'b1};
    end else begin
      r_acc <= r_acc;
      r_ovf <= r_ovf;
      r_cnt <= r_cnt;
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_busy      = r_busy;
  assign o_out_sum   = r_acc;
  assign o_out_ovf   = r_ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: scoreboard of expected frame results
// popped at each output handshake, plus a 17-bit accumulator instance for overflow.
module tb_product_accumulator;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic        rst_n;
  logic        a_start, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf, a_busy;
  logic [7:0]  a_len;
  logic [15:0] a_in_prod;
  logic [23:0] a_out_sum;

  logic        b_start, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf, b_busy;
  logic [7:0]  b_len;
  logic [15:0] b_in_prod;
  logic [16:0] b_out_sum;

  product_accumulator #(.PROD_W(16), .ACC_W(24), .LEN_W(8)) u_dut (
    .i_clk(i_clk), .i_rst_n(rst_n), .i_start(a_start), .i_len(a_len),
    .i_in_valid(a_in_valid), .o_in_ready(a_in_ready), .i_in_prod(a_in_prod),
    .o_out_valid(a_out_valid), .i_out_ready(a_out_ready), .o_out_sum(a_out_sum),
    .o_out_ovf(a_out_ovf), .o_busy(a_busy)
  );

  product_accumulator #(.PROD_W(16), .ACC_W(17), .LEN_W(8)) u_dut17 (
    .i_clk(i_clk), .i_rst_n(rst_n), .i_start(b_start), .i_len(b_len),
    .i_in_valid(b_in_valid), .o_in_ready(b_in_ready), .i_in_prod(b_in_prod),
    .o_out_valid(b_out_valid), .i_out_ready(b_out_ready), .o_out_sum(b_out_sum),
    .o_out_ovf(b_out_ovf), .o_busy(b_busy)
  );

  typedef struct packed {
    logic [23:0] sum;
    logic        ovf;
  } res_t;

  res_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   xfers, rdy_cycles, ov_cycles;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Output monitor: counts handshake activity and pops the scoreboard on each result.
  always @(negedge i_clk) begin : mon
    res_t r;
    if (rst_n) begin
      if (a_in_valid && a_in_ready) xfers++;
      if (a_in_ready) rdy_cycles++;
      if (a_out_valid) ov_cycles++;
      if (a_out_valid && a_out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 32'd1, 32'd0);
        end else begin
          r = sb.pop_front();
          chk("sb_sum", {8'd0, a_out_sum}, {8'd0, r.sum});
          chk("sb_ovf", {31'd0, a_out_ovf}, {31'd0, r.ovf});
        end
      end
    end
  end

  // One frame on the 24-bit instance: products base + i*step, optional idle gaps,
  // `hold` cycles of back-pressure, optional start pokes during ACCUM/HOLD.
  task automatic run_frame(input int n, input logic [15:0] base, input logic [15:0] step,
                           input bit gap, input int hold, input bit poke);
    logic [24:0] t;
    logic [23:0] acc;
    logic        ovf;
    logic [15:0] p;
    res_t        e;
    acc = 24'd0;
    ovf = 1'b0;
    xfers = 0; rdy_cycles = 0; ov_cycles = 0;
    a_out_ready = (hold == 0);
    a_start = 1'b1;
    a_len   = n[7:0];
    tick();
    a_start = 1'b0;
    a_len   = 8'd9;
    chk("busy_after_start", {31'd0, a_busy}, 32'd1);
    chk("in_ready_after_start", {31'd0, a_in_ready}, (n != 0) ? 32'd1 : 32'd0);
    for (int i = 0; i < n; i++) begin
      if (gap) begin
        a_in_valid = 1'b0;
        a_in_prod  = 16'hAAAA;
        tick();
      end
      p = base + step * i[15:0];
      a_in_valid = 1'b1;
      a_in_prod  = p;
      if (poke) begin
        a_start = 1'b1;
        a_len   = 8'd1;
      end
      t   = {1'b0, acc} + {9'd0, p};
      acc = t[23:0];
      ovf = ovf | t[24];
      tick();
    end
    a_in_valid = 1'b0;
    a_start    = 1'b0;
    e.sum = acc;
    e.ovf = ovf;
    sb.push_back(e);
    chk("out_valid_rise", {31'd0, a_out_valid}, 32'd1);
    chk("out_sum_final", {8'd0, a_out_sum}, {8'd0, acc});
    for (int k = 0; k < hold; k++) begin
      if (poke) a_start = 1'b1;
      tick();
      chk("hold_valid", {31'd0, a_out_valid}, 32'd1);
      chk("hold_sum", {8'd0, a_out_sum}, {8'd0, acc});
    end
    a_start = 1'b0;
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    chk("idle_busy", {31'd0, a_busy}, 32'd0);
    chk("idle_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("idle_sum_kept", {8'd0, a_out_sum}, {8'd0, acc});
    chk("xfer_count", xfers, n);
    chk("in_ready_cycles", rdy_cycles, gap ? 2 * n : n);
    chk("out_valid_cycles", ov_cycles, hold + 1);
  endtask

  initial begin
    rst_n = 1'b0;
    a_start = 1'b0; a_len = 8'd0; a_in_valid = 1'b0; a_in_prod = 16'd0; a_out_ready = 1'b0;
    b_start = 1'b0; b_len = 8'd0; b_in_valid = 1'b0; b_in_prod = 16'd0; b_out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", {31'd0, a_in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("rst_busy", {31'd0, a_busy}, 32'd0);
    chk("rst_sum", {8'd0, a_out_sum}, 32'd0);
    chk("rst_ovf", {31'd0, a_out_ovf}, 32'd0);
    rst_n = 1'b1;
    tick();

    run_frame(3, 16'd100, 16'd100, 1'b0, 0, 1'b0);
    run_frame(0, 16'd0, 16'd0, 1'b0, 0, 1'b0);
    run_frame(4, 16'hFFFF, 16'd0, 1'b1, 5, 1'b0);
    chk("ovf_clear_ffff", {31'd0, a_out_ovf}, 32'd0);

    // 17-bit accumulator: 3 x 0xFFFF wraps and sets the sticky flag
    b_start = 1'b1; b_len = 8'd3;
    tick();
    b_start = 1'b0;
    b_in_valid = 1'b1; b_in_prod = 16'hFFFF;
    tick(); tick(); tick();
    b_in_valid = 1'b0;
    chk("a17_valid", {31'd0, b_out_valid}, 32'd1);
    chk("a17_sum", {15'd0, b_out_sum}, 32'h0FFFD);
    chk("a17_ovf", {31'd0, b_out_ovf}, 32'd1);
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    chk("a17_idle", {31'd0, b_busy}, 32'd0);
    b_start = 1'b1; b_len = 8'd1;
    tick();
    b_start = 1'b0;
    b_in_valid = 1'b1; b_in_prod = 16'd5;
    tick();
    b_in_valid = 1'b0;
    chk("a17_sum2", {15'd0, b_out_sum}, 32'd5);
    chk("a17_ovf2", {31'd0, b_out_ovf}, 32'd0);
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;

    run_frame(3, 16'd7, 16'd1, 1'b0, 3, 1'b1);

    // Reset mid-frame after 2 of 5 products
    a_start = 1'b1; a_len = 8'd5;
    tick();
    a_start = 1'b0;
    a_in_valid = 1'b1; a_in_prod = 16'd11;
    tick(); tick();
    a_in_valid = 1'b0;
    chk("pre_abort_sum", {8'd0, a_out_sum}, 32'd22);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", {31'd0, a_in_ready}, 32'd0);
    chk("abort_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("abort_busy", {31'd0, a_busy}, 32'd0);
    chk("abort_sum", {8'd0, a_out_sum}, 32'd0);
    chk("abort_ovf", {31'd0, a_out_ovf}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_abort_busy", {31'd0, a_busy}, 32'd0);
    chk("post_abort_in_ready", {31'd0, a_in_ready}, 32'd0);

    run_frame(2, 16'h1234, 16'd1, 1'b0, 0, 1'b0);
    chk("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
